// File: rtl/vid_pattern_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : vid_pkg                                                    |
// | Description : Shared types and constants for the video pattern source.   |
// |               Holds the pattern-mode enum, the timing FSM state encoding |
// |               and the colour-bar lookup table.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package vid_pkg;

    // Runtime pattern selection. The encoding matches the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_RAMP  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_t;

    // Timing FSM state encoding.
    typedef logic [0:0] state_t;
    localparam state_t c_st_idle = 1'b0;
    localparam state_t c_st_run  = 1'b1;

    // Colour bars, left to right: white, yellow, cyan, green, magenta, red,
    // blue, black. Each entry is {r,g,b}.
    localparam logic [23:0] c_bar_lut [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage
`default_nettype wire

// File: rtl/vid_pattern_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : vid_pattern_gen_if                                         |
// | Description : Video pixel bundle {r,g,b,de,hsync,vsync} as consumed by   |
// |               the detector pipeline.                                     |
// |               master : the source driving pixels and timing              |
// |               slave  : the sink consuming them                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface vid_pattern_gen_if;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       de;
    logic       hsync;
    logic       vsync;

    modport master (output r, g, b, de, hsync, vsync);
    modport slave  (input  r, g, b, de, hsync, vsync);
endinterface
`default_nettype wire

// File: rtl/vid_timing_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vid_timing_cnt                                             |
// | Description : Horizontal/vertical counters, run/idle FSM, frame counter  |
// |               and combinational de/sync/frame-start decode of the        |
// |               current counter state.                                     |
// |   clk, rst        : clock, synchronous active-high reset                 |
// |   i_ce            : clock enable; all state holds when low               |
// |   i_enable        : run request, honoured at frame boundaries            |
// |   i_mode          : pattern mode, latched into o_mode_q per frame        |
// |   o_hcnt/o_vcnt   : current pixel position                               |
// |   o_run           : FSM is in RUN                                        |
// |   o_de/o_hsync_act/o_vsync_act/o_frame_start : decode of current state   |
// |   o_frame_count   : completed frames, wraps at 16 bits                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vid_timing_cnt
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ce,
    input  logic          i_enable,
    input  logic [1:0]    i_mode,
    output logic [CW-1:0] o_hcnt,
    output logic [CW-1:0] o_vcnt,
    output mode_t         o_mode_q,
    output logic          o_run,
    output logic          o_de,
    output logic          o_hsync_act,
    output logic          o_vsync_act,
    output logic          o_frame_start,
    output logic [15:0]   o_frame_count
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] c_h_last   = CW'(c_h_total - 1);
    localparam logic [CW-1:0] c_v_last   = CW'(c_v_total - 1);
    localparam logic [CW-1:0] c_h_act    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_v_act    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_hs_begin = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_hs_end   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_vs_begin = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_vs_end   = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Colour bars need eight equal columns, and both totals must fit in CW.
    generate
        if ((H_ACTIVE % 8) != 0 || c_h_total >= (1 << CW) || c_v_total >= (1 << CW)) begin : g_param_err
            $error("vid_timing_cnt: H_ACTIVE must be a multiple of 8 and H/V totals must fit in CW bits");
        end
    endgenerate

    state_t        r_state;
    logic [CW-1:0] r_hcnt;
    logic [CW-1:0] r_vcnt;
    mode_t         r_mode_q;
    logic [15:0]   r_frame_count;

    logic w_run;
    logic w_h_end;
    logic w_v_end;

    assign w_run   = (r_state == c_st_run);
    assign w_h_end = (r_hcnt == c_h_last);
    assign w_v_end = (r_vcnt == c_v_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_mode_q      <= MODE_SOLID;
            r_frame_count <= '0;
        end else if (i_ce) begin
            case (r_state)
                c_st_idle: begin
                    if (i_enable) begin
                        r_state  <= c_st_run;
                        r_mode_q <= mode_t'(i_mode);
                    end
                end
                c_st_run: begin
                    if (w_h_end) begin
                        r_hcnt <= '0;
                        if (w_v_end) begin
                            // Frame boundary: the only point where enable and
                            // mode are acted on, so a frame is never truncated.
                            r_vcnt        <= '0;
                            r_frame_count <= r_frame_count + 16'd1;
                            if (i_enable) begin
                                r_mode_q <= mode_t'(i_mode);
                            end else begin
                                r_state <= c_st_idle;
                            end
                        end else begin
                            r_vcnt <= r_vcnt + CW'(1);
                        end
                    end else begin
                        r_hcnt <= r_hcnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;
    assign o_mode_q      = r_mode_q;
    assign o_run         = w_run;
    assign o_frame_count = r_frame_count;

    assign o_de          = w_run && (r_hcnt < c_h_act) && (r_vcnt < c_v_act);
    assign o_hsync_act   = w_run && (r_hcnt >= c_hs_begin) && (r_hcnt < c_hs_end);
    assign o_vsync_act   = w_run && (r_vcnt >= c_vs_begin) && (r_vcnt < c_vs_end);
    assign o_frame_start = w_run && (r_hcnt == '0) && (r_vcnt == '0);

endmodule
`default_nettype wire

// File: rtl/vid_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vid_pattern_gen                                            |
// | Description : Parametrised video test-pattern source. Generates de/sync  |
// |               timing and RGB patterns (solid, bars, ramp, checkerboard). |
// |               All outputs are registered one cycle after the counters.   |
// |   clk, reset   : pixel clock, synchronous active-high reset              |
// |   ce           : clock enable; everything holds when low                 |
// |   enable       : run request (stop takes effect at end of frame)         |
// |   mode         : 0 solid, 1 bars, 2 ramp, 3 checkerboard                 |
// |   solid_rgb    : {r,g,b} for solid mode, sampled live                    |
// |   vid          : pixel bundle {r,g,b,de,hsync,vsync} (master)            |
// |   frame_start  : one-cycle pulse on pixel (0,0)                          |
// |   busy         : a frame is in progress                                  |
// |   frame_count  : completed frames, wraps at 16 bits                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vid_pattern_gen
    import vid_pkg::*;
#(
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int V_ACTIVE   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter int SYNC_POL   = 1,
    parameter int CHECK_LOG2 = 4,
    parameter int CW         = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic [23:0]              solid_rgb,
    vid_pattern_gen_if.master        vid,
    output logic                     frame_start,
    output logic                     busy,
    output logic [15:0]              frame_count
);

    localparam logic          c_sync_on  = (SYNC_POL != 0);
    localparam logic          c_sync_off = ~c_sync_on;
    localparam logic [CW-1:0] c_bar_w    = CW'(H_ACTIVE / 8);
    localparam logic [CW-1:0] c_chk_mask = CW'(1) << CHECK_LOG2;

    logic [CW-1:0] w_hcnt;
    logic [CW-1:0] w_vcnt;
    mode_t         w_mode_q;
    logic          w_run;
    logic          w_de;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_fs;
    logic [2:0]    w_bar;
    logic [7:0]    w_ramp;
    logic          w_chk;
    logic [23:0]   w_rgb;

    vid_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CW       (CW)
    ) u_timing (
        .clk           (clk),
        .rst           (reset),
        .i_ce          (ce),
        .i_enable      (enable),
        .i_mode        (mode),
        .o_hcnt        (w_hcnt),
        .o_vcnt        (w_vcnt),
        .o_mode_q      (w_mode_q),
        .o_run         (w_run),
        .o_de          (w_de),
        .o_hsync_act   (w_hs_act),
        .o_vsync_act   (w_vs_act),
        .o_frame_start (w_fs),
        .o_frame_count (frame_count)
    );

    // Bar index is only meaningful inside the active area, where it is 0..7.
    assign w_bar  = 3'(w_hcnt / c_bar_w);
    assign w_ramp = 8'(w_hcnt);
    // Checker square select: XOR of the CHECK_LOG2 bit of both counters.
    assign w_chk  = |((w_hcnt ^ w_vcnt) & c_chk_mask);

    always_comb begin
        w_rgb = '0;
        if (w_de) begin
            case (w_mode_q)
                MODE_SOLID: w_rgb = solid_rgb;
                MODE_BARS:  w_rgb = c_bar_lut[w_bar];
                MODE_RAMP:  w_rgb = {3{w_ramp}};
                MODE_CHECK: w_rgb = w_chk ? 24'hFFFFFF : 24'h000000;
                default:    w_rgb = '0;
            endcase
        end
    end

    logic [23:0] r_rgb;
    logic        r_de;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_frame_start;
    logic        r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb         <= '0;
            r_de          <= 1'b0;
            r_hsync       <= c_sync_off;
            r_vsync       <= c_sync_off;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else if (ce) begin
            r_rgb         <= w_rgb;
            r_de          <= w_de;
            r_hsync       <= w_hs_act ? c_sync_on : c_sync_off;
            r_vsync       <= w_vs_act ? c_sync_on : c_sync_off;
            r_frame_start <= w_fs;
            r_busy        <= w_run;
        end
    end

    assign vid.r       = r_rgb[23:16];
    assign vid.g       = r_rgb[15:8];
    assign vid.b       = r_rgb[7:0];
    assign vid.de      = r_de;
    assign vid.hsync   = r_hsync;
    assign vid.vsync   = r_vsync;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vid_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vid_pattern_gen                                         |
// | Description : Self-checking bench for vid_pattern_gen using a small      |
// |               14x7 raster and a frame-position reference model.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vid_pattern_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 14
    localparam int VT = VA + VF + VS + VB;   // 7
    localparam int FL = HT * VT;             // 98
    localparam int CL = 1;
    localparam bit SP = 1'b1;

    localparam logic [23:0] BARS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        enable;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic        frame_start;
    logic        busy;
    logic [15:0] frame_count;

    vid_pattern_gen_if vid ();

    vid_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1), .CHECK_LOG2 (CL), .CW (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .enable      (enable),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .vid         (vid),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Reference model: a generator is either idle or at linear position
    // m_pos (0..FL-1) inside a frame drawn with pattern m_mode.
    bit          m_run = 1'b0;
    int          m_pos = 0;
    logic [1:0]  m_mode = 2'd0;
    int          m_fc = 0;
    logic [23:0] e_rgb = '0;
    logic        e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_fs = 1'b0, e_busy = 1'b0;

    task automatic model_edge();
        int  h, v;
        bit  hs_on, vs_on;
        h = m_pos % HT;
        v = m_pos / HT;
        if (reset) begin
            m_run = 1'b0; m_pos = 0; m_mode = 2'd0; m_fc = 0;
            e_rgb = '0; e_de = 1'b0; e_hs = !SP; e_vs = !SP; e_fs = 1'b0; e_busy = 1'b0;
        end else if (ce) begin
            // Outputs show the pixel the generator was on before this edge.
            e_de   = m_run && (h < HA) && (v < VA);
            hs_on  = m_run && (h >= HA + HF) && (h < HA + HF + HS);
            vs_on  = m_run && (v >= VA + VF) && (v < VA + VF + VS);
            e_hs   = SP ? hs_on : !hs_on;
            e_vs   = SP ? vs_on : !vs_on;
            e_fs   = m_run && (m_pos == 0);
            e_busy = m_run;
            e_rgb  = 24'h000000;
            if (e_de) begin
                case (m_mode)
                    2'd0: e_rgb = solid_rgb;
                    2'd1: e_rgb = BARS[3'(h * 8 / HA)];
                    2'd2: e_rgb = {3{8'(h % 256)}};
                    default: e_rgb = ((((h >> CL) ^ (v >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
                endcase
            end
            if (!m_run) begin
                if (enable) begin m_run = 1'b1; m_pos = 0; m_mode = mode; end
            end else if (m_pos == FL - 1) begin
                m_fc  = (m_fc + 1) % 65536;
                m_pos = 0;
                if (enable) m_mode = mode;
                else        m_run = 1'b0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    function automatic logic [44:0] exp_b();
        return {e_rgb, e_de, e_hs, e_vs, e_fs, e_busy, 16'(m_fc)};
    endfunction

    function automatic logic [44:0] obs_b();
        return {vid.r, vid.g, vid.b, vid.de, vid.hsync, vid.vsync, frame_start, busy, frame_count};
    endfunction

    localparam logic [44:0] RESET_B = {24'h0, 1'b0, !SP, !SP, 1'b0, 1'b0, 16'h0};

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1; enable = 1'b0; mode = 2'd1; solid_rgb = 24'h0;
        tick(); tick();
        n_vec++;
        if (obs_b() !== RESET_B) begin
            n_miss++; $display("FAIL reset_state: got %h want %h", obs_b(), RESET_B);
        end
        reset = 1'b0; enable = 1'b1;
        tick(); tick(); tick();
        n_vec++;
        if (obs_b() !== exp_b()) begin
            n_miss++; $display("FAIL reset_run: got %h want %h", obs_b(), exp_b());
        end
        // Reset must win over a low clock enable.
        ce = 1'b0; reset = 1'b1;
        tick();
        n_vec++;
        if (obs_b() !== RESET_B) begin
            n_miss++; $display("FAIL reset_over_ce: got %h want %h", obs_b(), RESET_B);
        end
        ce = 1'b1;
    endtask

    task automatic test_bars();
        int fs_last, n_fs, n_de, n_vs, first_hs;
        logic [23:0] line0[$];
        reset = 1'b1; enable = 1'b0; ce = 1'b1; mode = 2'd1;
        tick();
        reset = 1'b0; enable = 1'b1;
        fs_last = -1; n_fs = 0; n_de = 0; n_vs = 0; first_hs = -1;
        for (int t = 1; t <= 2 * FL + 1; t++) begin
            tick();
            n_vec++;
            if (obs_b() !== exp_b()) begin
                n_miss++; $display("FAIL bars_stream t=%0d: got %h want %h", t, obs_b(), exp_b());
            end
            if (frame_start === 1'b1) begin
                if (fs_last >= 0) begin
                    n_vec++;
                    if (t - fs_last != FL) begin
                        n_miss++; $display("FAIL bars_fs_period: got %0d want %0d", t - fs_last, FL);
                    end
                end
                fs_last = t; n_fs++;
            end
            if (vid.de === 1'b1) n_de++;
            if (vid.vsync === 1'b1) n_vs++;
            if (vid.hsync === 1'b1 && first_hs < 0) first_hs = t;
            if (t >= 2 && t < 2 + HA) line0.push_back({vid.r, vid.g, vid.b});
        end
        for (int i = 0; i < HA; i++) begin
            n_vec++;
            if (line0[i] !== BARS[3'(i)]) begin
                n_miss++; $display("FAIL bars_line0 px%0d: got %h want %h", i, line0[i], BARS[3'(i)]);
            end
        end
        n_vec++;
        if (n_fs != 2 || n_de != 2 * HA * VA || n_vs != 2 * HT) begin
            n_miss++; $display("FAIL bars_counts: got fs=%0d de=%0d vs=%0d want 2 %0d %0d", n_fs, n_de, n_vs, 2 * HA * VA, 2 * HT);
        end
        // de covers t=2..9, falls at t=10, hsync rises two pixels later.
        n_vec++;
        if (first_hs != 2 + HA + HF) begin
            n_miss++; $display("FAIL bars_hsync_pos: got %0d want %0d", first_hs, 2 + HA + HF);
        end
    endtask

    task automatic test_stop();
        int  n_busy, n_de;
        bit  dropped;
        reset = 1'b1; enable = 1'b0; ce = 1'b1; mode = 2'($urandom_range(0, 3)); solid_rgb = 24'($urandom);
        tick();
        reset = 1'b0; enable = 1'b1;
        n_busy = 0; n_de = 0; dropped = 1'b0;
        for (int t = 1; t <= FL + 20; t++) begin
            tick();
            if (!dropped && m_run && m_pos == 30) begin enable = 1'b0; dropped = 1'b1; end
            n_vec++;
            if (obs_b() !== exp_b()) begin
                n_miss++; $display("FAIL stop_stream t=%0d: got %h want %h", t, obs_b(), exp_b());
            end
            if (busy === 1'b1) n_busy++;
            if (vid.de === 1'b1) n_de++;
        end
        n_vec++;
        if (n_busy != FL || n_de != HA * VA) begin
            n_miss++; $display("FAIL stop_frame_len: got busy=%0d de=%0d want %0d %0d", n_busy, n_de, FL, HA * VA);
        end
        n_vec++;
        if (frame_count !== 16'd1 || busy !== 1'b0 || vid.de !== 1'b0 || vid.hsync !== !SP || vid.vsync !== !SP) begin
            n_miss++; $display("FAIL stop_final: got fc=%0d busy=%b de=%b hs=%b vs=%b want 1 0 0 %b %b",
                               frame_count, busy, vid.de, vid.hsync, vid.vsync, !SP, !SP);
        end
    endtask

    task automatic test_mode_change();
        int n_fs, t_fs2;
        bit switched;
        logic [23:0] want, q0[$], q2[$];
        reset = 1'b1; enable = 1'b0; ce = 1'b1; mode = 2'd1;
        tick();
        reset = 1'b0; enable = 1'b1;
        n_fs = 0; t_fs2 = -1; switched = 1'b0;
        for (int t = 1; t <= 3 * FL; t++) begin
            tick();
            if (!switched && m_run && m_pos == 40) begin mode = 2'd3; switched = 1'b1; end
            n_vec++;
            if (obs_b() !== exp_b()) begin
                n_miss++; $display("FAIL mode_stream t=%0d: got %h want %h", t, obs_b(), exp_b());
            end
            // Pixel (2,3) of the frame already running must still be a bar.
            if (t == 2 + 3 * HT + 2) begin
                n_vec++;
                if ({vid.r, vid.g, vid.b} !== 24'h00FFFF) begin
                    n_miss++; $display("FAIL mode_hold_bars: got %h want %h", {vid.r, vid.g, vid.b}, 24'h00FFFF);
                end
            end
            if (frame_start === 1'b1) begin n_fs++; if (n_fs == 2) t_fs2 = t; end
            if (t_fs2 >= 0) begin
                if (t < t_fs2 + HA) q0.push_back({vid.r, vid.g, vid.b});
                if (t >= t_fs2 + 2 * HT && t < t_fs2 + 2 * HT + HA) q2.push_back({vid.r, vid.g, vid.b});
                if (t >= t_fs2 + 3 * HT) break;
            end
        end
        n_vec++;
        if (t_fs2 < 0 || q0.size() != HA || q2.size() != HA) begin
            n_miss++; $display("FAIL mode_timeout: got fs2=%0d q0=%0d q2=%0d want lines of %0d", t_fs2, q0.size(), q2.size(), HA);
        end else begin
            for (int i = 0; i < HA; i++) begin
                want = (((i >> CL) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
                n_vec++;
                if (q0[i] !== want) begin
                    n_miss++; $display("FAIL mode_check_line0 px%0d: got %h want %h", i, q0[i], want);
                end
                n_vec++;
                if (q2[i] !== ~want) begin
                    n_miss++; $display("FAIL mode_check_line2 px%0d: got %h want %h", i, q2[i], ~want);
                end
            end
        end
    endtask

    task automatic test_ce();
        int t_fs1, t_fs2;
        reset = 1'b1; enable = 1'b0; ce = 1'b1; mode = 2'($urandom_range(0, 3)); solid_rgb = 24'($urandom);
        tick();
        reset = 1'b0; enable = 1'b1;
        t_fs1 = -1; t_fs2 = -1;
        for (int t = 1; t <= 2 * FL + 20; t++) begin
            ce = (t >= 23 && t < 28) ? 1'b0 : 1'b1;
            tick();
            n_vec++;
            if (obs_b() !== exp_b()) begin
                n_miss++; $display("FAIL ce_stream t=%0d: got %h want %h", t, obs_b(), exp_b());
            end
            if (frame_start === 1'b1) begin
                if (t_fs1 < 0) t_fs1 = t;
                else begin t_fs2 = t; break; end
            end
        end
        ce = 1'b1;
        n_vec++;
        if (t_fs1 < 0 || t_fs2 < 0 || t_fs2 - t_fs1 != FL + 5) begin
            n_miss++; $display("FAIL ce_frame_len: got %0d want %0d", t_fs2 - t_fs1, FL + 5);
        end
    endtask

    task automatic test_reset_mid();
        int wait_fs;
        reset = 1'b1; enable = 1'b0; ce = 1'b1; mode = 2'($urandom_range(0, 3)); solid_rgb = 24'($urandom);
        tick();
        reset = 1'b0; enable = 1'b1;
        for (int t = 1; t <= 2 * FL; t++) begin
            tick();
            n_vec++;
            if (obs_b() !== exp_b()) begin
                n_miss++; $display("FAIL rstmid_stream t=%0d: got %h want %h", t, obs_b(), exp_b());
            end
            if (m_fc == 1 && m_pos == 50) break;
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if (obs_b() !== RESET_B) begin
            n_miss++; $display("FAIL rstmid_state: got %h want %h", obs_b(), RESET_B);
        end
        reset = 1'b0;
        wait_fs = -1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (frame_start === 1'b1) begin wait_fs = t; break; end
        end
        n_vec++;
        if (wait_fs != 2 || vid.de !== 1'b1) begin
            n_miss++; $display("FAIL rstmid_restart: got fs_at=%0d de=%b want 2 1", wait_fs, vid.de);
        end
    endtask

    task automatic test_solid();
        reset = 1'b1; enable = 1'b0; ce = 1'b1; mode = 2'd0; solid_rgb = 24'h123456;
        tick();
        reset = 1'b0; enable = 1'b1;
        for (int t = 1; t <= 2 * FL + 1; t++) begin
            tick();
            if (vid.de === 1'b1) begin
                n_vec++;
                if ({vid.r, vid.g, vid.b} !== 24'h123456) begin
                    n_miss++; $display("FAIL solid_px t=%0d: got %h want %h", t, {vid.r, vid.g, vid.b}, 24'h123456);
                end
            end
        end
        n_vec++;
        if (frame_count !== 16'd2) begin
            n_miss++; $display("FAIL solid_frame_count: got %0d want 2", frame_count);
        end
    endtask

    task automatic test_random();
        reset = 1'b1; ce = 1'b1; enable = 1'b1;
        tick();
        reset = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            ce        = ($urandom_range(0, 4) != 0);
            reset     = ($urandom_range(0, 999) == 0);
            mode      = 2'($urandom_range(0, 3));
            solid_rgb = 24'($urandom);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            tick();
            n_vec++;
            if (obs_b() !== exp_b()) begin
                n_miss++; $display("FAIL random_stream t=%0d: got %h want %h", t, obs_b(), exp_b());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; enable = 1'b0; mode = 2'd0; solid_rgb = 24'h0;
        test_reset();
        test_bars();
        test_stop();
        test_mode_change();
        test_ce();
        test_reset_mid();
        test_solid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
